neighbor_serializer: RTL and testbench

//  Transmit side of the per-node neighbour-value link. Captures NUM_NBR W-bit

---
 rtl/neighbor_serializer.sv | 143 ++++++++++++++
 tb/tb_neighbor_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_serializer.sv
// Neighbour-value frame transmitter: parallel capture of NUM_NBR values,
// then one value per beat on a narrow valid/ready bus with slot index.
module neighbor_serializer #(
   parameter int             NUM_NBR  = 4,
   parameter int             W        = 2,
   parameter logic [W-1:0]   IDLE_VAL = {W{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 high,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [NUM_NBR*W-1:0] nbr_flat,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [W-1:0]         tx_data,
   output logic [2:0]           tx_slot,
   output logic                 tx_first,
   output logic                 tx_last,
   output logic                 frame_done
);

   localparam int         BW   = NUM_NBR * W;
   localparam logic [2:0] LAST = 3'(NUM_NBR - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [BW-1:0] buf_q, buf_d;
   logic          load_ready_q, load_ready_d;
   logic          tx_valid_q, tx_valid_d;
   logic [W-1:0]  tx_data_q, tx_data_d;
   logic [2:0]    tx_slot_q, tx_slot_d;
   logic [2:0]    slot_nxt;
   logic          tx_first_q, tx_first_d;
   logic          tx_last_q, tx_last_d;
   logic          frame_done_q, frame_done_d;

   assign slot_nxt = tx_slot_q + 3'd1;

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      tx_slot_d    = tx_slot_q;
      tx_first_d   = tx_first_q;
      tx_last_d    = tx_last_q;
      frame_done_d = 1'b0;
      if (!high) begin
         // Dropping enable abandons the frame without a completion pulse
         state_d    = IDLE;
         tx_valid_d = 1'b0;
         tx_data_d  = IDLE_VAL;
         tx_slot_d  = 3'd0;
         tx_first_d = 1'b0;
         tx_last_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               tx_valid_d = 1'b0;
               tx_data_d  = IDLE_VAL;
               tx_slot_d  = 3'd0;
               tx_first_d = 1'b0;
               tx_last_d  = 1'b0;
               if (load_valid) begin
                  buf_d      = nbr_flat;
                  state_d    = SEND;
                  tx_valid_d = 1'b1;
                  tx_data_d  = nbr_flat[W-1:0];
                  tx_first_d = 1'b1;
                  tx_last_d  = (LAST == 3'd0);
               end
            end
            SEND: begin
               if (tx_valid_q && tx_ready) begin
                  if (tx_slot_q == LAST) begin
                     state_d      = DONE;
                     tx_valid_d   = 1'b0;
                     tx_data_d    = IDLE_VAL;
                     tx_first_d   = 1'b0;
                     tx_last_d    = 1'b0;
                     frame_done_d = 1'b1;
                  end else begin
                     tx_slot_d  = slot_nxt;
                     tx_data_d  = buf_q[slot_nxt*W +: W];
                     tx_first_d = 1'b0;
                     tx_last_d  = (slot_nxt == LAST);
                  end
               end
            end
            DONE: begin
               state_d   = IDLE;
               tx_slot_d = 3'd0;
            end
            default: begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
               tx_data_d  = IDLE_VAL;
               tx_slot_d  = 3'd0;
               tx_first_d = 1'b0;
               tx_last_d  = 1'b0;
            end
         endcase
      end
      load_ready_d = high && (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         buf_q        <= {NUM_NBR{IDLE_VAL}};
         load_ready_q <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= IDLE_VAL;
         tx_slot_q    <= 3'd0;
         tx_first_q   <= 1'b0;
         tx_last_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         load_ready_q <= load_ready_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         tx_slot_q    <= tx_slot_d;
         tx_first_q   <= tx_first_d;
         tx_last_q    <= tx_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign load_ready = load_ready_q;
   assign tx_valid   = tx_valid_q;
   assign tx_data    = tx_data_q;
   assign tx_slot    = tx_slot_q;
   assign tx_first   = tx_first_q;
   assign tx_last    = tx_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_neighbor_serializer.sv
// Bench for neighbor_serializer: directed table, corner sequences and
// random traffic against a beat-queue reference model.
module tb_neighbor_serializer;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst, high, load_valid, tx_ready;
   logic [7:0]   nbr_flat;
   logic         load_ready, tx_valid, tx_first, tx_last, frame_done;
   logic [1:0]   tx_data;
   logic [2:0]   tx_slot;
   logic         load_ready1, tx_valid1, tx_first1, tx_last1, frame_done1;
   logic [1:0]   tx_data1;
   logic [2:0]   tx_slot1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neighbor_serializer #(.NUM_NBR(4), .W(2), .IDLE_VAL(2'b11)) u_dut (
      .clk(clk), .rst(rst), .high(high),
      .load_valid(load_valid), .load_ready(load_ready),
      .nbr_flat(nbr_flat),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_slot(tx_slot), .tx_first(tx_first), .tx_last(tx_last),
      .frame_done(frame_done)
   );

   neighbor_serializer #(.NUM_NBR(1), .W(2), .IDLE_VAL(2'b11)) u_dut1 (
      .clk(clk), .rst(rst), .high(high),
      .load_valid(load_valid), .load_ready(load_ready1),
      .nbr_flat(nbr_flat[1:0]),
      .tx_valid(tx_valid1), .tx_ready(tx_ready), .tx_data(tx_data1),
      .tx_slot(tx_slot1), .tx_first(tx_first1), .tx_last(tx_last1),
      .frame_done(frame_done1)
   );

   // Reference model: a frame is a queue of pending beats
   typedef struct {
      logic [1:0] d;
      int         s;
   } beat_t;

   beat_t      bq[$];
   bit         m_valid, m_done, m_ready, m_first, m_last;
   logic [1:0] m_data;
   int         m_slot;

   task automatic model_step();
      beat_t b;
      bit    idle;
      idle = !m_valid && !m_done;
      if (rst) begin
         bq.delete();
         m_done  = 0;
         m_ready = 0;
      end else if (!high) begin
         bq.delete();
         m_done  = 0;
         m_ready = 0;
      end else begin
         m_done = 0;
         if (m_valid && tx_ready) begin
            b = bq.pop_front();
            if (bq.size() == 0) m_done = 1;
         end else if (idle && load_valid) begin
            for (int i = 0; i < N; i++) begin
               b.d = nbr_flat[i*2 +: 2];
               b.s = i;
               bq.push_back(b);
            end
         end
      end
      m_valid = bq.size() > 0;
      if (!rst && high) m_ready = !m_valid && !m_done;
      m_data  = m_valid ? bq[0].d : 2'b11;
      m_slot  = m_valid ? bq[0].s : 0;
      m_first = m_valid && (m_slot == 0);
      m_last  = m_valid && (m_slot == N - 1);
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("valid", 32'(tx_valid), 32'(m_valid));
      chk("data", 32'(tx_data), 32'(m_data));
      chk("ready", 32'(load_ready), 32'(m_ready));
      chk("done", 32'(frame_done), 32'(m_done));
      chk("first", 32'(tx_first), 32'(m_first));
      chk("last", 32'(tx_last), 32'(m_last));
      if (!m_done) chk("slot", 32'(tx_slot), 32'(m_slot));
   endtask

   typedef struct {
      bit         rst, high, lv, txr;
      logic [7:0] nbr;
      bit         valid;
      logic [1:0] data;
      logic [2:0] slot;
      bit         first, last, done, ready;
   } vec_t;

   vec_t tbl[9];
   int   n;

   initial begin
      tbl[0] = '{1,1,0,1,8'h00, 0,2'b11,0,0,0,0,0};
      tbl[1] = '{1,1,0,1,8'h00, 0,2'b11,0,0,0,0,0};
      tbl[2] = '{0,1,0,1,8'h00, 0,2'b11,0,0,0,0,1};
      tbl[3] = '{0,1,1,1,8'h1B, 1,2'b11,0,1,0,0,0};
      tbl[4] = '{0,1,0,1,8'h00, 1,2'b10,1,0,0,0,0};
      tbl[5] = '{0,1,0,1,8'h00, 1,2'b01,2,0,0,0,0};
      tbl[6] = '{0,1,0,1,8'h00, 1,2'b00,3,0,1,0,0};
      tbl[7] = '{0,1,0,1,8'h00, 0,2'b11,0,0,0,1,0};
      tbl[8] = '{0,1,0,1,8'h00, 0,2'b11,0,0,0,0,1};

      rst = 1; high = 1; load_valid = 0; tx_ready = 1; nbr_flat = 0;
      m_valid = 0; m_done = 0; m_ready = 0;

      // Reset and a full unstalled frame
      for (int i = 0; i < 9; i++) begin
         rst        = tbl[i].rst;
         high       = tbl[i].high;
         load_valid = tbl[i].lv;
         tx_ready   = tbl[i].txr;
         nbr_flat   = tbl[i].nbr;
         cycle();
         chk("t_valid", 32'(tx_valid), 32'(tbl[i].valid));
         chk("t_data", 32'(tx_data), 32'(tbl[i].data));
         chk("t_ready", 32'(load_ready), 32'(tbl[i].ready));
         chk("t_done", 32'(frame_done), 32'(tbl[i].done));
         chk("t_first", 32'(tx_first), 32'(tbl[i].first));
         chk("t_last", 32'(tx_last), 32'(tbl[i].last));
         if (!tbl[i].done) chk("t_slot", 32'(tx_slot), 32'(tbl[i].slot));
      end

      // Backpressure at slot 1, plus an ignored mid-frame load
      load_valid = 1; nbr_flat = 8'h1B; tx_ready = 1;
      cycle();
      load_valid = 0;
      cycle();
      chk("stall_slot1", 32'(tx_slot), 32'd1);
      tx_ready = 0;
      for (int i = 0; i < 3; i++) begin
         load_valid = (i == 1);
         nbr_flat   = (i == 1) ? 8'hFF : 8'h1B;
         cycle();
         chk("hold_data", 32'(tx_data), 32'h2);
         chk("hold_slot", 32'(tx_slot), 32'd1);
         chk("hold_ready", 32'(load_ready), 32'd0);
      end
      load_valid = 0; tx_ready = 1;
      cycle();
      chk("after_ignore", 32'(tx_data), 32'h1);
      n = 0;
      while (!frame_done && n < 10) begin
         cycle();
         n++;
      end
      chk("stall_done", 32'(frame_done), 32'd1);
      cycle();

      // Enable dropped at slot 2
      load_valid = 1; nbr_flat = 8'h1B;
      cycle();
      load_valid = 0;
      n = 0;
      while (tx_slot != 3'd2 && n < 10) begin
         cycle();
         n++;
      end
      chk("reach_slot2", 32'(tx_slot), 32'd2);
      high = 0;
      cycle();
      chk("abort_valid", 32'(tx_valid), 32'd0);
      chk("abort_data", 32'(tx_data), 32'h3);
      chk("abort_done", 32'(frame_done), 32'd0);
      high = 1;
      cycle();
      load_valid = 1; nbr_flat = 8'hE4;
      cycle();
      load_valid = 0;
      chk("restart_slot", 32'(tx_slot), 32'd0);
      chk("restart_data", 32'(tx_data), 32'h0);

      // Reset mid-frame at slot 1
      cycle();
      chk("at_slot1", 32'(tx_slot), 32'd1);
      rst = 1;
      cycle();
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'h3);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd0);

      // Single-neighbour build
      rst = 0;
      cycle();
      chk("n1_ready", 32'(load_ready1), 32'd1);
      load_valid = 1; nbr_flat = 8'h1B; tx_ready = 1;
      cycle();
      load_valid = 0;
      chk("n1_valid", 32'(tx_valid1), 32'd1);
      chk("n1_data", 32'(tx_data1), 32'h3);
      chk("n1_first", 32'(tx_first1), 32'd1);
      chk("n1_last", 32'(tx_last1), 32'd1);
      cycle();
      chk("n1_done", 32'(frame_done1), 32'd1);
      chk("n1_idle", 32'(tx_valid1), 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 59) == 0);
         high       = ($urandom_range(0, 19) != 0);
         load_valid = ($urandom_range(0, 2) == 0);
         tx_ready   = ($urandom_range(0, 9) < 6);
         nbr_flat   = 8'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
